i2c_eeprom_slave: RTL and testbench
===================================

# i2c_eeprom_slave

Synthesisable, parametrised I2C EEPROM slave with internal byte memory, running entirely in the system clock domain with oversampled SCL/SDA. It is the successor to the behavioural serial EEPROM model: it adds configurable address width and page size, page-write wrap, sequential and random read, repeated START, write protect and open-drain output. It sits behind the board-level I2C pads, and its memory serves as the non-volatile-style store for test benches and FPGA builds.

## Interface
- ADDR_W, 11, memory address width; depth = 2^ADDR_W bytes; legal range 8..11
- PAGE_W, 4, page size = 2^PAGE_W bytes; PAGE_W < ADDR_W
- DEV_ID, 4'b1010, device-type code matched against control byte [7:4]
- clk  input  1  system clock; must be ≥ 10× SCL frequency
- rst  input  1  reset, asynchronous, active-high
- scl_i  input  1  SCL pad input (asynchronous)
- sda_i  input  1  SDA pad input (asynchronous)
- sda_oe  output  1  1 = pull SDA low (open drain); 0 = release
- wp  input  1  write protect; 1 = data bytes NACKed and not stored
- busy  output  1  1 from START detect until STOP, reset, or transaction abort

## Operation
- scl_i/sda_i each pass through a 2-flop synchroniser plus a 1-flop history stage. START = synced SDA falls while SCL is high; STOP = synced SDA rises while SCL is high. Data bits are sampled on synced SCL rising edges, MSB first.
- Control byte = {DEV_ID, A[ADDR_W-1:8] in bits [3:1] (unused bits ignored, zero-extended), R/W in bit 0}. A mismatch on [7:4] means no ACK, state goes to IDLE, and busy drops.
- States: IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT (ignore bus until START/STOP).
- A START in any state (repeated START included) moves to CTRL with bit count 0. A STOP in any state moves to IDLE.
- CTRL_ACK: on R/W = 0 go to ADDR; on R/W = 1 go to RDATA, reading from the internal pointer (current-address read). The upper address bits from the control byte are loaded into the pointer only on a write control byte.
- ADDR: low 8 bits loaded; pointer = {ctrl bits, addr byte}; always ACKed; then WDATA.
- WDATA: on each full byte with wp = 0, ACK, write mem[pointer], then increment only pointer[PAGE_W-1:0] (wraps inside the page; upper bits unchanged). With wp = 1, NACK, no write, pointer unchanged, and state goes to WAIT.
- RDATA: shift out mem[pointer], then increment the pointer modulo 2^ADDR_W (sequential read wraps the full memory). A master ACK goes to the next byte. A master NACK releases SDA and goes to WAIT.
- Memory contents are not reset. The pointer resets to 0 and persists across transactions.

## Timing
- Reset values: sda_oe = 0, busy = 0, state = IDLE, pointer = 0, bit counter = 0, shift register = 0. Reset mid-transfer releases SDA at once and leaves memory intact.
- Detection latency is 3 clk from the pad edge to the internal event.
- sda_oe changes only on the clk after a detected SCL falling edge, never while SCL is high.
- ACK: sda_oe = 1 is set after the SCL fall that ends bit 8. It is held through the 9th SCL high and cleared after the following SCL fall.
- Read bit: sda_oe = ~data_bit is set after the preceding SCL fall, the first bit after the SCL fall that ends the ACK. SDA is released during the master ACK slot.
- Write commit: the mem write occurs in the clk cycle the ACK is driven. A read of that byte in the next transaction returns the new value. There is no write-cycle busy time.
- A STOP or START that coincides with an ACK slot takes priority, and sda_oe is released the next clk.

## Test plan
- Write control 0xA0, address 0x10, data 0x5A, STOP; then control 0xA0, address 0x10, repeated START, control 0xA1, master NACK. Required: every byte ACKed, and 0x5A is read back.
- Page wrap with PAGE_W = 4: write 0x0E, data 0x01..0x04. Required: mem[0x0E] = 0x01, mem[0x0F] = 0x02, mem[0x00] = 0x03, mem[0x01] = 0x04.
- Sequential read from 0x7FF (ADDR_W = 11) over 3 bytes with master ACK, ACK, NACK. Required: bytes returned from 0x7FF, 0x000, 0x001; SDA released after the NACK.
- Control 0xB0 (wrong ID). Required: no ACK, busy = 0 after the 9th clock, and the next valid transaction works.
- wp = 1, write 0xA0/0x20/0x77. Required: address ACKed, data NACKed, mem[0x20] unchanged.
- Assert rst during the 5th read bit. Required: sda_oe = 0 and busy = 0 within 1 clk; the subsequent current-address read returns mem[0].

Source files
------------

// File: rtl/i2c_eeprom_slave.sv
// I2C EEPROM slave with an internal byte memory. SCL/SDA are oversampled in
// the clk domain; all protocol decisions happen on detected bus events.
`timescale 1ns/1ps
module i2c_eeprom_slave #(
    parameter int         ADDR_W = 11,
    parameter int         PAGE_W = 4,
    parameter logic [3:0] DEV_ID = 4'b1010
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe,
    input  logic wp,
    output logic busy
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_CTRL      = 4'd1;
    localparam logic [3:0] ST_CTRL_ACK  = 4'd2;
    localparam logic [3:0] ST_ADDR      = 4'd3;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_WAIT      = 4'd9;

    // Bit 1 carries SCL, bit 0 carries SDA through every stage.
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;
    logic [1:0] hist_reg;

    logic scl_s, scl_h, sda_s, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]        state_reg, state_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [2:0]        ctrl_hi_reg, ctrl_hi_next;
    logic              rw_reg, rw_next;
    logic              master_ack_reg, master_ack_next;
    logic              sda_oe_reg, sda_oe_next;

    logic [ADDR_W-1:0] ptr_page_inc;
    logic [10:0]       addr_full;
    logic              mem_we;

    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] rd_data_reg;

    // Two-flop synchroniser plus one history flop per pad; reset to the idle-high bus level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 2'b11;
            sync_reg <= 2'b11;
            hist_reg <= 2'b11;
        end else begin
            meta_reg <= {scl_i, sda_i};
            sync_reg <= meta_reg;
            hist_reg <= sync_reg;
        end
    end

    assign scl_s     = sync_reg[1];
    assign scl_h     = hist_reg[1];
    assign sda_s     = sync_reg[0];
    assign sda_h     = hist_reg[0];
    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    assign start_det = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

    // Upper address bits come from the control byte; unused ones fall off the top.
    assign addr_full = {ctrl_hi_reg, shift_reg};

    // Page-write increment touches only the in-page offset bits.
    always_comb begin
        ptr_page_inc = ptr_reg;
        ptr_page_inc[PAGE_W-1:0] = ptr_reg[PAGE_W-1:0] + PAGE_W'(1);
    end

    // Protocol state machine: sample on SCL rise, drive SDA on SCL fall.
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        ptr_next        = ptr_reg;
        ctrl_hi_next    = ctrl_hi_reg;
        rw_next         = rw_reg;
        master_ack_next = master_ack_reg;
        sda_oe_next     = sda_oe_reg;
        mem_we          = 1'b0;

        if (stop_det) begin
            state_next   = ST_IDLE;
            sda_oe_next  = 1'b0;
            bit_cnt_next = 4'd0;
        end else if (start_det) begin
            state_next   = ST_CTRL;
            sda_oe_next  = 1'b0;
            bit_cnt_next = 4'd0;
        end else begin
            case (state_reg)
                ST_CTRL, ST_ADDR, ST_WDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_reg != 4'd8) begin
                            shift_next   = {shift_reg[6:0], sda_s};
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        bit_cnt_next = 4'd0;
                        case (state_reg)
                            ST_CTRL: begin
                                if (shift_reg[7:4] == DEV_ID) begin
                                    state_next  = ST_CTRL_ACK;
                                    sda_oe_next = 1'b1;
                                    rw_next     = shift_reg[0];
                                    if (!shift_reg[0]) begin
                                        ctrl_hi_next = shift_reg[3:1];
                                    end
                                end else begin
                                    state_next = ST_IDLE;
                                end
                            end
                            ST_ADDR: begin
                                ptr_next    = addr_full[ADDR_W-1:0];
                                sda_oe_next = 1'b1;
                                state_next  = ST_ADDR_ACK;
                            end
                            default: begin
                                if (!wp) begin
                                    mem_we      = 1'b1;
                                    sda_oe_next = 1'b1;
                                    ptr_next    = ptr_page_inc;
                                    state_next  = ST_WDATA_ACK;
                                end else begin
                                    state_next = ST_WAIT;
                                end
                            end
                        endcase
                    end
                end
                ST_CTRL_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = 4'd0;
                        if (rw_reg) begin
                            state_next  = ST_RDATA;
                            sda_oe_next = ~rd_data_reg[7];
                            shift_next  = {rd_data_reg[6:0], 1'b0};
                        end else begin
                            state_next  = ST_ADDR;
                            sda_oe_next = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_next   = ST_WDATA;
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = 4'd0;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_reg != 4'd8) begin
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_oe_next = 1'b0;
                            ptr_next    = ptr_reg + ADDR_W'(1);
                            state_next  = ST_RDATA_ACK;
                        end else begin
                            sda_oe_next = ~shift_reg[7];
                            shift_next  = {shift_reg[6:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        master_ack_next = ~sda_s;
                    end else if (scl_fall) begin
                        bit_cnt_next = 4'd0;
                        if (master_ack_reg) begin
                            state_next  = ST_RDATA;
                            sda_oe_next = ~rd_data_reg[7];
                            shift_next  = {rd_data_reg[6:0], 1'b0};
                        end else begin
                            state_next  = ST_WAIT;
                            sda_oe_next = 1'b0;
                        end
                    end
                end
                default: begin
                    // IDLE and WAIT ignore the bus until START or STOP.
                end
            endcase
        end
    end

    // Protocol registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 4'd0;
            shift_reg      <= 8'd0;
            ptr_reg        <= '0;
            ctrl_hi_reg    <= 3'd0;
            rw_reg         <= 1'b0;
            master_ack_reg <= 1'b0;
            sda_oe_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            ptr_reg        <= ptr_next;
            ctrl_hi_reg    <= ctrl_hi_next;
            rw_reg         <= rw_next;
            master_ack_reg <= master_ack_next;
            sda_oe_reg     <= sda_oe_next;
        end
    end

    // Byte memory: written in the cycle the data ACK is raised, read continuously at the pointer.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_reg] <= shift_reg;
        end
        rd_data_reg <= mem[ptr_reg];
    end

    assign sda_oe = sda_oe_reg;
    assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master, table vectors, directed
// corner cases and randomized traffic checked against a byte-array model.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;
    localparam int ADDR_W = 11;
    localparam int PAGE_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PAGE   = 1 << PAGE_W;
    localparam int Q      = 6;   // clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic rst, scl, msda, wp;
    logic sda_oe, busy;
    logic sda_bus;

    assign sda_bus = msda & ~sda_oe;
    always #5 clk = ~clk;

    i2c_eeprom_slave #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .DEV_ID(4'b1010)) dut (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus),
        .sda_oe(sda_oe), .wp(wp), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_model [DEPTH];
    bit         known     [DEPTH];
    int         ptr_model;
    int         wr_addrs [$];
    logic [7:0] wq [$];
    logic [7:0] rq [$];

    typedef struct {
        logic [7:0] ctrl;
        logic [7:0] addr;
        logic [7:0] data;
        logic       wpv;
        logic       exp_c;
        logic       exp_a;
        logic       exp_d;
    } vec_t;
    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic clock_bit(input logic d, output logic s);
        wait_q(); msda = d;
        wait_q(); scl = 1'b1;
        wait_q(); s = sda_bus;
        wait_q(); scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_q(); msda = 1'b1;
        wait_q(); scl = 1'b1;
        wait_q(); msda = 1'b0;
        wait_q(); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); msda = 1'b0;
        wait_q(); scl = 1'b1;
        wait_q(); msda = 1'b1;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(~mack, s);
    endtask

    // Write transaction: control, address, then every byte in wq until a NACK.
    task automatic write_txn(input logic [10:0] addr, input logic wpv,
                             output logic c_ack, output logic a_ack, output int d_acks);
        logic ak;
        wp = wpv;
        d_acks = 0;
        i2c_start();
        send_byte({4'hA, addr[10:8], 1'b0}, c_ack);
        send_byte(addr[7:0], a_ack);
        for (int i = 0; i < wq.size(); i++) begin
            send_byte(wq[i], ak);
            if (!ak) break;
            d_acks++;
        end
        i2c_stop();
        wp = 1'b0;
        $display("txn write addr=%03h n=%0d wp=%0d data_acks=%0d", addr, wq.size(), wpv, d_acks);
    endtask

    // Random read: dummy write to set the address, repeated START, read n bytes.
    task automatic read_random(input logic [10:0] addr, input int n, input bit do_stop,
                               output logic c_ack, output logic a_ack, output logic r_ack);
        logic [7:0] b;
        rq.delete();
        i2c_start();
        send_byte({4'hA, addr[10:8], 1'b0}, c_ack);
        send_byte(addr[7:0], a_ack);
        i2c_start();
        send_byte({4'hA, addr[10:8], 1'b1}, r_ack);
        for (int i = 0; i < n; i++) begin
            recv_byte(i != n - 1, b);
            rq.push_back(b);
        end
        if (do_stop) i2c_stop();
        $display("txn rand_read addr=%03h n=%0d", addr, n);
    endtask

    task automatic read_current(input int n, output logic r_ack);
        logic [7:0] b;
        rq.delete();
        i2c_start();
        send_byte(8'hA1, r_ack);
        for (int i = 0; i < n; i++) begin
            recv_byte(i != n - 1, b);
            rq.push_back(b);
        end
        i2c_stop();
        $display("txn cur_read n=%0d", n);
    endtask

    // Model: a page write stores bytes at successive offsets inside the page of addr.
    function automatic void model_write(input int addr, input bit wpv);
        int base;
        int a;
        base = addr & ~(PAGE - 1);
        ptr_model = addr;
        if (!wpv) begin
            for (int i = 0; i < wq.size(); i++) begin
                a = base | ((addr + i) % PAGE);
                mem_model[a] = wq[i];
                known[a] = 1'b1;
                wr_addrs.push_back(a);
            end
            ptr_model = base | ((addr + wq.size()) % PAGE);
        end
    endfunction

    // Model: sequential reads walk the whole memory and wrap at the top.
    task automatic check_read(input int start, input int n, input string tag);
        int a;
        for (int i = 0; i < n; i++) begin
            a = (start + i) % DEPTH;
            if (known[a]) check($sformatf("%s_b%0d@%03h", tag, i, a), rq[i], mem_model[a]);
        end
        ptr_model = (start + n) % DEPTH;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic c, a, r, s, ak;
        int   n, addr, len;
        logic [10:0] a11;

        rst = 1'b1; scl = 1'b1; msda = 1'b1; wp = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        ptr_model = 0;

        vecs[0] = '{8'hA0, 8'h40, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{8'hA2, 8'h41, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'hAE, 8'h42, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'hB0, 8'h50, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h20, 8'h51, 8'h98, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'hA0, 8'h43, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'hE0, 8'h52, 8'h97, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'hA4, 8'hFF, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (4) @(posedge clk);
        #1;
        check("reset_sda_oe", sda_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        wait_q();

        // Basic write then random read back.
        wq = '{8'h5A};
        write_txn(11'h010, 1'b0, c, a, n);
        check("t1_wr_ctrl_ack", c, 1'b1);
        check("t1_wr_addr_ack", a, 1'b1);
        check("t1_wr_data_acks", n, 1);
        model_write(11'h010, 1'b0);
        read_random(11'h010, 1, 1'b1, c, a, r);
        check("t1_rd_ctrl_ack", r, 1'b1);
        check("t1_rd_value", rq[0], 8'h5A);
        check_read(11'h010, 1, "t1");
        check("t1_idle_busy", busy, 1'b0);

        // Page wrap inside a 16-byte page.
        wq = '{8'h01, 8'h02, 8'h03, 8'h04};
        write_txn(11'h00E, 1'b0, c, a, n);
        check("t2_data_acks", n, 4);
        model_write(11'h00E, 1'b0);
        read_random(11'h00E, 2, 1'b1, c, a, r);
        check("t2_mem_0e", rq[0], 8'h01);
        check("t2_mem_0f", rq[1], 8'h02);
        check_read(11'h00E, 2, "t2a");
        read_random(11'h000, 2, 1'b1, c, a, r);
        check("t2_mem_00", rq[0], 8'h03);
        check("t2_mem_01", rq[1], 8'h04);
        check_read(11'h000, 2, "t2b");

        // Sequential read across the top of memory.
        wq = '{8'hC1};
        write_txn(11'h7FF, 1'b0, c, a, n);
        model_write(11'h7FF, 1'b0);
        wq = '{8'hC2, 8'hC3};
        write_txn(11'h000, 1'b0, c, a, n);
        model_write(11'h000, 1'b0);
        read_random(11'h7FF, 3, 1'b0, c, a, r);
        check("t3_b0_7ff", rq[0], 8'hC1);
        check("t3_b1_000", rq[1], 8'hC2);
        check("t3_b2_001", rq[2], 8'hC3);
        check_read(11'h7FF, 3, "t3");
        clock_bit(1'b1, s);
        check("t3_sda_released", s, 1'b1);
        check("t3_sda_oe_after_nack", sda_oe, 1'b0);
        check("t3_busy_in_wait", busy, 1'b1);
        i2c_stop();
        check("t3_busy_after_stop", busy, 1'b0);

        // Wrong device ID, then a normal transaction.
        i2c_start();
        send_byte(8'hB0, c);
        check("t4_wrong_id_ack", c, 1'b0);
        check("t4_wrong_id_busy", busy, 1'b0);
        i2c_stop();
        wq = '{8'h9C};
        write_txn(11'h123, 1'b0, c, a, n);
        check("t4_next_ctrl_ack", c, 1'b1);
        model_write(11'h123, 1'b0);
        read_random(11'h123, 1, 1'b1, c, a, r);
        check("t4_next_value", rq[0], 8'h9C);
        check_read(11'h123, 1, "t4");

        // Write protect.
        wq = '{8'h3C};
        write_txn(11'h020, 1'b0, c, a, n);
        model_write(11'h020, 1'b0);
        wq = '{8'h77};
        write_txn(11'h020, 1'b1, c, a, n);
        check("t5_wp_addr_ack", a, 1'b1);
        check("t5_wp_data_acks", n, 0);
        model_write(11'h020, 1'b1);
        read_random(11'h020, 1, 1'b1, c, a, r);
        check("t5_mem_unchanged", rq[0], 8'h3C);
        check_read(11'h020, 1, "t5");

        // Table-driven single-byte writes.
        for (int v = 0; v < NV; v++) begin
            wp = vecs[v].wpv;
            i2c_start();
            send_byte(vecs[v].ctrl, c);
            check($sformatf("vec%0d_ctrl_ack", v), c, vecs[v].exp_c);
            if (c) begin
                check($sformatf("vec%0d_busy", v), busy, 1'b1);
                send_byte(vecs[v].addr, a);
                check($sformatf("vec%0d_addr_ack", v), a, vecs[v].exp_a);
                send_byte(vecs[v].data, ak);
                check($sformatf("vec%0d_data_ack", v), ak, vecs[v].exp_d);
            end else begin
                check($sformatf("vec%0d_busy", v), busy, 1'b0);
            end
            i2c_stop();
            wp = 1'b0;
            $display("txn vec%0d ctrl=%02h addr=%02h data=%02h wp=%0d", v,
                     vecs[v].ctrl, vecs[v].addr, vecs[v].data, vecs[v].wpv);
            if (vecs[v].ctrl[7:4] == 4'hA && !vecs[v].ctrl[0]) begin
                wq = '{vecs[v].data};
                model_write({vecs[v].ctrl[3:1], vecs[v].addr}, vecs[v].wpv);
            end
        end
        for (int v = 0; v < NV; v++) begin
            if (vecs[v].ctrl[7:4] == 4'hA) begin
                a11 = {vecs[v].ctrl[3:1], vecs[v].addr};
                read_random(a11, 1, 1'b1, c, a, r);
                check_read(a11, 1, $sformatf("vec%0d_rb", v));
            end
        end

        // Reset during the 5th bit of a read byte (0xA5: 5th bit is 0, so SDA is pulled).
        wq = '{8'hA5};
        write_txn(11'h030, 1'b0, c, a, n);
        model_write(11'h030, 1'b0);
        read_random(11'h030, 0, 1'b0, c, a, r);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
        wait_q(); msda = 1'b1;
        wait_q(); scl = 1'b1;
        wait_q();
        check("t6_bit5_driven", sda_oe, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_sda_oe", sda_oe, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ptr_model = 0;
        wait_q();
        read_current(1, r);
        check("t6_cur_ctrl_ack", r, 1'b1);
        check("t6_cur_read_mem0", rq[0], 8'hC2);
        check_read(0, 1, "t6");

        // Randomized traffic against the model.
        for (int it = 0; it < 14; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    addr = $urandom_range(0, DEPTH - 1);
                    len  = $urandom_range(1, 5);
                    wq.delete();
                    for (int i = 0; i < len; i++) wq.push_back(8'($urandom_range(0, 255)));
                    ak = ($urandom_range(0, 3) == 0);
                    write_txn(11'(addr), ak, c, a, n);
                    check($sformatf("rnd%0d_ctrl_ack", it), c, 1'b1);
                    check($sformatf("rnd%0d_addr_ack", it), a, 1'b1);
                    check($sformatf("rnd%0d_data_acks", it), n, ak ? 0 : len);
                    model_write(addr, ak);
                end
                1: begin
                    addr = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                    len  = $urandom_range(1, 4);
                    read_random(11'(addr), len, 1'b1, c, a, r);
                    check($sformatf("rnd%0d_rd_ack", it), r, 1'b1);
                    check_read(addr, len, $sformatf("rnd%0d", it));
                end
                default: begin
                    len = $urandom_range(1, 3);
                    addr = ptr_model;
                    read_current(len, r);
                    check($sformatf("rnd%0d_cur_ack", it), r, 1'b1);
                    check_read(addr, len, $sformatf("rnd%0d_cur", it));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
